// File: rtl/flash_read_arbiter.sv
`default_nettype none
// ============================================================================
// flash_read_arbiter : round-robin sharing of the Flash SPI read handler
// Rev 1.0 - initial release
// ============================================================================
module flash_read_arbiter #(
   parameter int G_NUM_REQ        = 3,
   parameter int G_TIMEOUT_CYCLES = 65535,
   parameter int G_ADDR_MAX_WIDTH = 17
) (
   input  logic                    i_sys_clk,
   input  logic                    i_reset,
   input  logic [G_NUM_REQ-1:0]    i_req,
   input  logic [24*G_NUM_REQ-1:0] i_req_addr,
   input  logic [12*G_NUM_REQ-1:0] i_req_num,
   output logic [G_NUM_REQ-1:0]    o_grant,
   output logic [G_NUM_REQ-1:0]    o_done,
   output logic [G_NUM_REQ-1:0]    o_error,
   input  logic                    i_bus_busy,
   output logic                    o_bus_claim,
   output logic                    o_data_request,
   output logic [23:0]             o_read_addr,
   output logic [11:0]             o_read_num,
   input  logic                    i_data_ready,
   input  logic                    i_command_error
);

   localparam int IDX_W = (G_NUM_REQ > 1) ? $clog2(G_NUM_REQ) : 1;
   localparam int CNT_W = 17;
   localparam logic [IDX_W:0]   NUM_REQ_EXT  = (IDX_W+1)'(G_NUM_REQ);
   localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(G_NUM_REQ - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(G_TIMEOUT_CYCLES - 1);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] ARB      = 2'd1;
   localparam logic [1:0] REQ      = 2'd2;
   localparam logic [1:0] WAIT_LOW = 2'd3;

   logic [1:0]             state;
   logic [IDX_W-1:0]       rr_ptr;
   logic [IDX_W-1:0]       winner;
   logic [CNT_W-1:0]       timeout_cnt;

   logic [2*G_NUM_REQ-1:0] req_dbl;
   logic [IDX_W-1:0]       offset;
   logic [IDX_W:0]         pick_sum;
   logic [IDX_W-1:0]       pick;
   logic [23:0]            pick_addr;
   logic [11:0]            pick_num;
   logic                   addr_oob;

   // Rotate the request vector so the RR pointer sits at bit 0, take the
   // lowest set bit, then rotate the offset back into a requester index.
   always_comb begin
      req_dbl = {i_req, i_req} >> rr_ptr;
      offset  = '0;
      for (int i = G_NUM_REQ - 1; i >= 0; i--) begin
         if (req_dbl[i]) offset = IDX_W'(i);
      end
      pick_sum = {1'b0, rr_ptr} + {1'b0, offset};
      if (pick_sum >= NUM_REQ_EXT) pick_sum = pick_sum - NUM_REQ_EXT;
      pick      = pick_sum[IDX_W-1:0];
      pick_addr = '0;
      pick_num  = '0;
      for (int i = 0; i < G_NUM_REQ; i++) begin
         if (pick == IDX_W'(i)) begin
            pick_addr = i_req_addr[24*i +: 24];
            pick_num  = i_req_num[12*i +: 12];
         end
      end
   end

   generate
      if (G_ADDR_MAX_WIDTH >= 24) begin : g_addr_full
         assign addr_oob = 1'b0;
      end else begin : g_addr_limited
         assign addr_oob = |o_read_addr[23:G_ADDR_MAX_WIDTH];
      end
   endgenerate

   always_ff @(posedge i_sys_clk or posedge i_reset) begin
      if (i_reset) begin
         state          <= IDLE;
         rr_ptr         <= '0;
         winner         <= '0;
         timeout_cnt    <= '0;
         o_grant        <= '0;
         o_done         <= '0;
         o_error        <= '0;
         o_bus_claim    <= 1'b0;
         o_data_request <= 1'b0;
         o_read_addr    <= '0;
         o_read_num     <= '0;
      end else begin
         o_done  <= '0;
         o_error <= '0;
         case (state)
            IDLE: begin
               if (|i_req && !i_bus_busy) begin
                  winner      <= pick;
                  o_grant     <= G_NUM_REQ'(1) << pick;
                  o_bus_claim <= 1'b1;
                  o_read_addr <= pick_addr;
                  o_read_num  <= pick_num;
                  state       <= ARB;
               end
            end
            ARB: begin
               if (o_read_num == '0 || addr_oob) begin
                  o_error <= o_grant;
                  state   <= WAIT_LOW;
               end else begin
                  o_data_request <= 1'b1;
                  timeout_cnt    <= '0;
                  state          <= REQ;
               end
            end
            REQ: begin
               if (i_command_error) begin
                  o_error        <= o_grant;
                  o_data_request <= 1'b0;
                  state          <= WAIT_LOW;
               end else if (i_data_ready) begin
                  o_done         <= o_grant;
                  o_data_request <= 1'b0;
                  state          <= WAIT_LOW;
               end else if (timeout_cnt == TIMEOUT_LAST) begin
                  o_error        <= o_grant;
                  o_data_request <= 1'b0;
                  state          <= WAIT_LOW;
               end else begin
                  timeout_cnt <= timeout_cnt + 1'b1;
               end
            end
            WAIT_LOW: begin
               // The bus stays claimed until the handler closes its handshake.
               if (!i_data_ready) begin
                  o_grant     <= '0;
                  o_bus_claim <= 1'b0;
                  rr_ptr      <= (winner == LAST_IDX) ? '0 : winner + 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/flash_read_arbiter.md
Name: flash_read_arbiter

Overview:
Shares the single Flash SPI read handler among up to G_NUM_REQ on-chip requesters, such as the schedule loader and display/UI fetch.
- Arbitrates round-robin and claims the shared SPI bus from other SPI masters.
- Sequences the handler's request / data_ready four-phase handshake.
- Returns a per-requester done or error pulse.
- Read data is not routed through this block; the granted requester samples the handler's o_data on its o_done pulse.

Parameters:
G_NUM_REQ, 3, number of requesters (2..4)
G_TIMEOUT_CYCLES, 65535, max sys clock cycles in REQ before abort (fits 17-bit counter)
G_ADDR_MAX_WIDTH, 17, flash address bits; addresses at or above 2**G_ADDR_MAX_WIDTH are rejected

Ports:
i_sys_clk  in  1  system clock, all logic on rising edge
i_reset  in  1  asynchronous, active-high reset
i_req  in  G_NUM_REQ  per-requester read request, level, held until o_done/o_error
i_req_addr  in  24*G_NUM_REQ  requester k address in bits [24k+23:24k]
i_req_num  in  12*G_NUM_REQ  requester k byte count in bits [12k+11:12k]
o_grant  out  G_NUM_REQ  one-hot, current owner of handler
o_done  out  G_NUM_REQ  1-cycle pulse, handler data valid for owner
o_error  out  G_NUM_REQ  1-cycle pulse, request rejected/failed/timed out
i_bus_busy  in  1  another SPI master owns the bus
o_bus_claim  out  1  this block owns the SPI bus
o_data_request  out  1  to handler i_data_request
o_read_addr  out  24  to handler i_read_addr
o_read_num  out  12  to handler i_read_num
i_data_ready  in  1  from handler o_data_ready
i_command_error  in  1  from handler o_command_error

Behaviour:
- Reset: all outputs 0, state IDLE, RR pointer 0, timeout counter 0. Reset mid-transaction drops o_data_request and o_bus_claim immediately (async). No done/error is issued for the aborted transaction.
- States: IDLE, ARB, REQ, WAIT_LOW.
- IDLE -> ARB:
  - Transition when |i_req and !i_bus_busy.
  - Winner is the first asserted i_req scanning from the RR pointer upward, wrapping at G_NUM_REQ-1 -> 0.
  - Registered on entry: o_grant=onehot(winner), o_bus_claim=1, o_read_addr/o_read_num = winner's fields.
- ARB (1 cycle):
  - If num==0 or addr >= 2**G_ADDR_MAX_WIDTH: pulse o_error[winner], go to WAIT_LOW without raising o_data_request.
  - Else: o_data_request=1, clear timeout counter, go to REQ.
- REQ, checks in priority order:
  1. i_command_error=1: o_error pulse, drop o_data_request, go to WAIT_LOW.
  2. i_data_ready=1: o_done pulse, drop o_data_request, go to WAIT_LOW.
  3. Counter == G_TIMEOUT_CYCLES-1: o_error pulse, drop o_data_request, go to WAIT_LOW.
  4. Otherwise: counter+1.
- WAIT_LOW:
  - Hold o_grant and o_bus_claim until i_data_ready==0.
  - Then go to IDLE; clear o_grant and o_bus_claim.
  - RR pointer = (winner+1) mod G_NUM_REQ.
- Latency: i_req in IDLE at edge N -> o_grant/o_bus_claim at N+1 -> o_data_request at N+2. i_data_ready high at edge M -> o_done at M+1.
- o_data_request is never high unless o_bus_claim is high. o_grant is exactly one-hot or zero.
- i_bus_busy is sampled only in IDLE. Once claimed, the bus is held until WAIT_LOW completes.
- Requests are sampled only at arbitration:
  - Deasserting i_req mid-transaction is ignored; the transaction completes and o_done/o_error still pulse.
  - i_req still high on return to IDLE counts as a new request.
- Request fields are latched at arbitration; later changes are ignored.
- Requests arriving in states other than IDLE wait. There is no queue depth beyond the i_req levels themselves.

Test Plan:
- Single read: req[0]=1, addr=0x000005, num=16, handler data_ready after 300 cycles -> o_data_request at N+2, addr/num match, o_done[0] one cycle, claim released after data_ready falls.
- Round-robin: req[0..2] held continuously, each num=8 -> grant order 0,1,2,0; each o_done exactly once per grant; o_grant never multi-hot.
- Bus busy: i_bus_busy=1 with req[1]=1 for 50 cycles -> no claim/grant; i_bus_busy falls -> grant[1] on next cycle.
- Rejects: req[2] num=0 -> o_error[2], no o_data_request; addr=0x020000 -> o_error, no o_data_request.
- Failure paths, G_TIMEOUT_CYCLES=100:
  - i_command_error pulse in REQ -> o_error, request dropped.
  - Handler never readies -> o_error exactly 100 cycles after o_data_request rise.
- Reset mid-REQ: assert i_reset -> all outputs 0 asynchronously. After release, pending req[1] is granted first (pointer 0 restarts scan, req[0] low).
